// File: rtl/float_mult_scheduler.sv
// Queues operand pairs and drives one STB/ACK multiplier core, one op at a time.
// Optional WAIT_Z watchdog: define FLOAT_MULT_SCHED_TIMEOUT_EN.
module float_mult_scheduler #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 4,
   parameter int CH_W    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                       i_CLK,
   input  logic                       i_RST,
   input  logic [DATA_W-1:0]          i_A,
   input  logic [DATA_W-1:0]          i_B,
   input  logic [CH_W-1:0]            i_CH,
   input  logic                       i_IN_VALID,
   output logic                       o_IN_READY,
   output logic [DATA_W-1:0]          o_CORE_A,
   output logic [DATA_W-1:0]          o_CORE_B,
   output logic                       o_CORE_AB_STB,
   input  logic                       i_CORE_AB_ACK,
   input  logic [DATA_W-1:0]          i_CORE_Z,
   input  logic                       i_CORE_Z_STB,
   output logic                       o_CORE_Z_ACK,
   output logic [DATA_W-1:0]          o_Z,
   output logic [CH_W-1:0]            o_Z_CH,
   output logic                       o_Z_VALID,
   input  logic                       i_Z_READY,
   output logic [$clog2(DEPTH):0]     o_COUNT,
   output logic                       o_BUSY,
   output logic                       o_TIMEOUT
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_Z, HOLD} state_t;

   state_t            state;
   logic [DATA_W-1:0] mem_a  [DEPTH];
   logic [DATA_W-1:0] mem_b  [DEPTH];
   logic [CH_W-1:0]   mem_ch [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic [CH_W-1:0]   tag;
   logic              full;
   logic              push;
   logic              pop;
   logic              has_head;

   assign full       = (count == CW'(DEPTH));
   assign push       = i_IN_VALID && !full;
   assign pop        = (state == ISSUE) && i_CORE_AB_ACK;
   assign has_head   = (count != '0);
   assign o_IN_READY = !full;
   assign o_COUNT    = count;
   assign o_BUSY     = (state != IDLE) || has_head;

`ifdef FLOAT_MULT_SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd_cnt;
`else
   assign o_TIMEOUT = 1'b0;
`endif

   // Storage needs no reset; validity is tracked by the pointers/count.
   always_ff @(posedge i_CLK) begin
      if (push) begin
         mem_a[wr_ptr]  <= i_A;
         mem_b[wr_ptr]  <= i_B;
         mem_ch[wr_ptr] <= i_CH;
      end
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state         <= IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         tag           <= '0;
         o_CORE_A      <= '0;
         o_CORE_B      <= '0;
         o_CORE_AB_STB <= 1'b0;
         o_CORE_Z_ACK  <= 1'b0;
         o_Z           <= '0;
         o_Z_CH        <= '0;
         o_Z_VALID     <= 1'b0;
`ifdef FLOAT_MULT_SCHED_TIMEOUT_EN
         wd_cnt        <= '0;
         o_TIMEOUT     <= 1'b0;
`endif
      end else begin
         o_CORE_Z_ACK <= 1'b0;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;

         unique case (state)
            IDLE: begin
               if (has_head) begin
                  o_CORE_A      <= mem_a[rd_ptr];
                  o_CORE_B      <= mem_b[rd_ptr];
                  tag           <= mem_ch[rd_ptr];
                  o_CORE_AB_STB <= 1'b1;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               if (i_CORE_AB_ACK) begin
                  o_CORE_AB_STB <= 1'b0;
                  state         <= WAIT_Z;
               end
            end
            WAIT_Z: begin
               if (i_CORE_Z_STB) begin
                  o_Z          <= i_CORE_Z;
                  o_Z_CH       <= tag;
                  o_Z_VALID    <= 1'b1;
                  o_CORE_Z_ACK <= 1'b1;
                  state        <= HOLD;
`ifdef FLOAT_MULT_SCHED_TIMEOUT_EN
                  wd_cnt       <= '0;
               end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                  // Core never answered: hand back a quiet NaN
                  o_Z       <= DATA_W'(32'h7FC0_0000);
                  o_Z_CH    <= tag;
                  o_Z_VALID <= 1'b1;
                  o_TIMEOUT <= 1'b1;
                  wd_cnt    <= '0;
                  state     <= HOLD;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
`endif
               end
            end
            HOLD: begin
               if (i_Z_READY) begin
                  o_Z_VALID <= 1'b0;
                  if (has_head) begin
                     o_CORE_A      <= mem_a[rd_ptr];
                     o_CORE_B      <= mem_b[rd_ptr];
                     tag           <= mem_ch[rd_ptr];
                     o_CORE_AB_STB <= 1'b1;
                     state         <= ISSUE;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_float_mult_scheduler.sv
// Scoreboard bench for float_mult_scheduler with a behavioural core model.
// Timeout checks run when FLOAT_MULT_SCHED_TIMEOUT_EN is defined.
module tb_float_mult_scheduler;

   logic        clk = 1'b0;
   logic        i_RST;
   logic [31:0] i_A, i_B;
   logic [1:0]  i_CH;
   logic        i_IN_VALID, o_IN_READY;
   logic [31:0] o_CORE_A, o_CORE_B;
   logic        o_CORE_AB_STB, i_CORE_AB_ACK;
   logic [31:0] i_CORE_Z;
   logic        i_CORE_Z_STB, o_CORE_Z_ACK;
   logic [31:0] o_Z;
   logic [1:0]  o_Z_CH;
   logic        o_Z_VALID, i_Z_READY;
   logic [2:0]  o_COUNT;
   logic        o_BUSY, o_TIMEOUT;

   logic        core_ack = 0, core_zs = 0, man_ack = 0, man_zs = 0;
   logic [31:0] core_z = 0, man_z = 0;
   logic        core_stall = 0, core_mute = 0, rand_core = 0;
   logic        core_fixed_en = 0;
   logic [31:0] core_fixed = 32'hAA55AA55;
   int          ack_d = 1, z_lat = 3;

   assign i_CORE_AB_ACK = core_ack | man_ack;
   assign i_CORE_Z_STB  = core_zs | man_zs;
   assign i_CORE_Z      = man_zs ? man_z : core_z;

   always #5 clk = ~clk;

   float_mult_scheduler #(
      .DATA_W(32), .DEPTH(4), .CH_W(2), .TIMEOUT(8)
   ) dut (
      .i_CLK(clk), .i_RST(i_RST),
      .i_A(i_A), .i_B(i_B), .i_CH(i_CH),
      .i_IN_VALID(i_IN_VALID), .o_IN_READY(o_IN_READY),
      .o_CORE_A(o_CORE_A), .o_CORE_B(o_CORE_B),
      .o_CORE_AB_STB(o_CORE_AB_STB), .i_CORE_AB_ACK(i_CORE_AB_ACK),
      .i_CORE_Z(i_CORE_Z), .i_CORE_Z_STB(i_CORE_Z_STB),
      .o_CORE_Z_ACK(o_CORE_Z_ACK),
      .o_Z(o_Z), .o_Z_CH(o_Z_CH), .o_Z_VALID(o_Z_VALID),
      .i_Z_READY(i_Z_READY), .o_COUNT(o_COUNT),
      .o_BUSY(o_BUSY), .o_TIMEOUT(o_TIMEOUT)
   );

   typedef struct {
      logic [31:0] z;
      logic [1:0]  ch;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   // Stand-in arithmetic for the multiplier core
   function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b);
      return (a + (b << 1)) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] core_res(input logic [31:0] a, input logic [31:0] b);
      return core_fixed_en ? core_fixed : core_fn(a, b);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Core model: ACK after ack_d cycles, result z_lat cycles later
   initial begin : core_model
      int d, zl, k;
      logic [31:0] r;
      forever begin
         @(negedge clk);
         if (o_CORE_AB_STB && !core_stall && !i_RST) begin
            d  = rand_core ? int'($urandom_range(0, 3)) : ack_d;
            zl = rand_core ? int'($urandom_range(0, 4)) : z_lat;
            repeat (d) @(negedge clk);
            r = core_res(o_CORE_A, o_CORE_B);
            core_ack = 1'b1;
            @(negedge clk);
            core_ack = 1'b0;
            if (!core_mute) begin
               repeat (zl) @(negedge clk);
               core_z  = r;
               core_zs = 1'b1;
               k = 0;
               do begin
                  @(negedge clk);
                  k++;
               end while (!o_CORE_Z_ACK && k < 1000);
               core_zs = 1'b0;
            end
         end
      end
   end

   // Monitor: pop and compare on every output transfer, check holding
   logic        hold_prev = 0;
   logic [31:0] pz;
   logic [1:0]  pch;
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (i_RST) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            total++;
            if (!o_Z_VALID || o_Z !== pz || o_Z_CH !== pch) begin
               bad++;
               $display("FAIL hold_stable: got v=%b z=%h ch=%0d want v=1 z=%h ch=%0d",
                        o_Z_VALID, o_Z, o_Z_CH, pz, pch);
            end
         end
         if (o_Z_VALID && i_Z_READY) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_result: got z=%h ch=%0d want none", o_Z, o_Z_CH);
            end else begin
               e = sb.pop_front();
               if (o_Z !== e.z || o_Z_CH !== e.ch) begin
                  bad++;
                  $display("FAIL result: got z=%h ch=%0d want z=%h ch=%0d",
                           o_Z, o_Z_CH, e.z, e.ch);
               end
            end
         end
         hold_prev = o_Z_VALID && !i_Z_READY;
         pz  = o_Z;
         pch = o_Z_CH;
      end
   end

   task automatic push(input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] ch, input bit rec);
      @(negedge clk);
      i_A = a; i_B = b; i_CH = ch; i_IN_VALID = 1'b1;
      for (int k = 0; k < 400; k++) begin
         #1;
         if (o_IN_READY) begin
            if (rec) sb.push_back('{core_res(a, b), ch});
            @(negedge clk);
            i_IN_VALID = 1'b0;
            return;
         end
         @(negedge clk);
      end
      chk("push_accept", 32'd0, 32'd1);
      i_IN_VALID = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         #1;
         if (sb.size() == 0 && !o_BUSY && !o_Z_VALID) break;
      end
      chk("drain_sb", sb.size(), 0);
      chk("drain_busy", o_BUSY, 0);
   endtask

   task automatic check_reset_state(input string p);
      chk({p, "_ready"}, o_IN_READY, 1);
      chk({p, "_count"}, o_COUNT, 0);
      chk({p, "_stb"}, o_CORE_AB_STB, 0);
      chk({p, "_core_a"}, o_CORE_A, 0);
      chk({p, "_core_b"}, o_CORE_B, 0);
      chk({p, "_zack"}, o_CORE_Z_ACK, 0);
      chk({p, "_z"}, o_Z, 0);
      chk({p, "_zch"}, o_Z_CH, 0);
      chk({p, "_zvalid"}, o_Z_VALID, 0);
      chk({p, "_busy"}, o_BUSY, 0);
      chk({p, "_timeout"}, o_TIMEOUT, 0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "simulation time limit");
   end

   bit prod_done = 0;

   initial begin : main
      int vcnt, acnt, stbs, anyv, anyack, n;
      i_RST = 1; i_A = 0; i_B = 0; i_CH = 0;
      i_IN_VALID = 0; i_Z_READY = 0;
      repeat (3) @(negedge clk);
      i_RST = 0;
      #1 check_reset_state("reset");

      // Single op with a fixed core result
      i_Z_READY = 1; core_fixed_en = 1; ack_d = 1; z_lat = 3;
      push(32'hB4DC753A, 32'h34DC753A, 2'd2, 1);
      vcnt = 0; acnt = 0;
      repeat (30) begin
         @(negedge clk); #1;
         vcnt += int'(o_Z_VALID);
         acnt += int'(o_CORE_Z_ACK);
      end
      chk("single_valid_cycles", vcnt, 1);
      chk("single_zack_cycles", acnt, 1);
      core_fixed_en = 0;

      // Fill the queue with the core stalled
      i_Z_READY = 0; core_stall = 1;
      for (int i = 0; i < 4; i++) push($urandom, $urandom, 2'(i), 1);
      #1;
      chk("fill_ready", o_IN_READY, 0);
      chk("fill_count", o_COUNT, 4);
      fork
         push($urandom, $urandom, 2'd0, 1);
      join_none
      repeat (4) @(negedge clk);
      #1;
      chk("fill_held_count", o_COUNT, 4);
      chk("fill_held_ready", o_IN_READY, 0);
      core_stall = 0; i_Z_READY = 1;
      wait fork;
      drain();

      // Downstream backpressure with a second op queued
      i_Z_READY = 0; ack_d = 1; z_lat = 2;
      push($urandom, $urandom, 2'd3, 1);
      push($urandom, $urandom, 2'd1, 1);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk); #1;
         if (o_Z_VALID) break;
      end
      chk("bp_valid", o_Z_VALID, 1);
      stbs = 0;
      repeat (10) begin
         @(negedge clk); #1;
         stbs += int'(o_CORE_AB_STB);
      end
      chk("bp_no_stb", stbs, 0);
      @(negedge clk);
      i_Z_READY = 1;
      @(negedge clk); #1;
      chk("bp_stb_next", o_CORE_AB_STB, 1);
      drain();

      // Push and pop in the same cycle at count 2
      core_stall = 1;
      push(32'h1111_0000, 32'h2222_0000, 2'd1, 0);
      push(32'h3333_0000, 32'h4444_0000, 2'd2, 0);
      for (int k = 0; k < 50; k++) begin
         @(negedge clk); #1;
         if (o_COUNT == 2 && o_CORE_AB_STB) break;
      end
      chk("pp_pre_count", o_COUNT, 2);
      @(negedge clk);
      i_A = 32'h5555_0000; i_B = 32'h6666_0000; i_CH = 2'd3;
      i_IN_VALID = 1; man_ack = 1;
      @(negedge clk);
      i_IN_VALID = 0; man_ack = 0;
      #1;
      chk("pp_count", o_COUNT, 2);
      chk("pp_stb_cleared", o_CORE_AB_STB, 0);

      // Reset while waiting on the core, then a stray result
      @(negedge clk);
      i_RST = 1;
      @(negedge clk);
      i_RST = 0;
      man_z = 32'hDEAD_BEEF; man_zs = 1;
      anyv = 0; anyack = 0;
      repeat (4) begin
         @(negedge clk); #1;
         anyv += int'(o_Z_VALID);
         anyack += int'(o_CORE_Z_ACK);
      end
      chk("rst_stray_valid", anyv, 0);
      chk("rst_stray_zack", anyack, 0);
      check_reset_state("midrst");
      man_zs = 0; core_stall = 0;

      // Randomized traffic with random core timing and backpressure
      rand_core = 1;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               push($urandom, $urandom, 2'($urandom_range(0, 3)), 1);
            end
            prod_done = 1;
         end
         begin
            for (int k = 0; k < 4000; k++) begin
               @(negedge clk);
               if (prod_done && sb.size() == 0) break;
               i_Z_READY = ($urandom_range(0, 3) != 0);
            end
         end
      join
      i_Z_READY = 1; rand_core = 0;
      drain();

`ifdef FLOAT_MULT_SCHED_TIMEOUT_EN
      // Core never returns: quiet NaN after TIMEOUT cycles in WAIT_Z
      i_Z_READY = 0; core_mute = 1; ack_d = 1;
      push(32'h0BAD_F00D, 32'h1234_5678, 2'd1, 0);
      sb.push_back('{32'h7FC0_0000, 2'd1});
      for (int k = 0; k < 50; k++) begin
         @(negedge clk); #1;
         if (o_CORE_AB_STB && i_CORE_AB_ACK) break;
      end
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk); #1;
         if (o_Z_VALID) break;
         n++;
      end
      chk("to_latency", n, 8);
      chk("to_flag", o_TIMEOUT, 1);
      chk("to_nan", o_Z, 32'h7FC0_0000);
      @(negedge clk);
      i_Z_READY = 1; core_mute = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("to_sticky", o_TIMEOUT, 1);
      chk("to_consumed", o_Z_VALID, 0);
      @(negedge clk);
      i_RST = 1;
      @(negedge clk);
      i_RST = 0;
      #1 chk("to_cleared", o_TIMEOUT, 0);
`else
      chk("no_timeout_flag", o_TIMEOUT, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
